// File: rtl/arm_hazard_pkg.sv
// Shared types for the ARM pipeline hazard unit:
// forwarding select encodings and the memory-wait FSM states.
package arm_hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REGFILE   = 2'b00,
      FWD_WRITEBACK = 2'b01,
      FWD_MEMORY    = 2'b10
   } forward_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_t;

endpackage

// File: rtl/arm_hazard_unit_if.sv
// Hazard bus between the datapath/controller (master) and the hazard
// unit (slave): per-stage register/control info in, stall/flush/forward out.
interface arm_hazard_unit_if #(
   parameter int RegAddrWidth = 4,
   parameter int CntWidth     = 32
);
   logic [RegAddrWidth-1:0] i_SrcReg_A_Decode;
   logic [RegAddrWidth-1:0] i_SrcReg_B_Decode;
   logic [RegAddrWidth-1:0] i_SrcReg_A_Execute;
   logic [RegAddrWidth-1:0] i_SrcReg_B_Execute;
   logic [RegAddrWidth-1:0] i_DestReg_Execute;
   logic [RegAddrWidth-1:0] i_DestReg_Memory;
   logic [RegAddrWidth-1:0] i_DestReg_WriteBack;
   logic                    i_Reg_Write_Execute;
   logic                    i_Reg_Write_Memory;
   logic                    i_Reg_Write_WriteBack;
   logic                    i_Mem_To_Reg_Execute;
   logic                    i_PC_Write_Decode;
   logic                    i_PC_Write_Execute;
   logic                    i_PC_Write_Memory;
   logic                    i_PC_Src_WriteBack;
   logic                    i_Branch_Taken_Execute;
   logic                    i_Mem_Req_Memory;
   logic                    i_Mem_Ready;
   logic                    i_Cnt_Clear;
   logic [1:0]              o_Forward_A_Execute;
   logic [1:0]              o_Forward_B_Execute;
   logic                    o_Stall_Fetch;
   logic                    o_Stall_Decode;
   logic                    o_Stall_Execute;
   logic                    o_Stall_Memory;
   logic                    o_Flush_Decode;
   logic                    o_Flush_Execute;
   logic                    o_Flush_WriteBack;
   logic                    o_Mem_Wait;
   logic [CntWidth-1:0]     o_Stall_Count;
   logic [CntWidth-1:0]     o_Flush_Count;

   modport master (
      output i_SrcReg_A_Decode, i_SrcReg_B_Decode,
      output i_SrcReg_A_Execute, i_SrcReg_B_Execute,
      output i_DestReg_Execute, i_DestReg_Memory, i_DestReg_WriteBack,
      output i_Reg_Write_Execute, i_Reg_Write_Memory, i_Reg_Write_WriteBack,
      output i_Mem_To_Reg_Execute,
      output i_PC_Write_Decode, i_PC_Write_Execute, i_PC_Write_Memory,
      output i_PC_Src_WriteBack, i_Branch_Taken_Execute,
      output i_Mem_Req_Memory, i_Mem_Ready, i_Cnt_Clear,
      input  o_Forward_A_Execute, o_Forward_B_Execute,
      input  o_Stall_Fetch, o_Stall_Decode, o_Stall_Execute, o_Stall_Memory,
      input  o_Flush_Decode, o_Flush_Execute, o_Flush_WriteBack,
      input  o_Mem_Wait, o_Stall_Count, o_Flush_Count
   );

   modport slave (
      input  i_SrcReg_A_Decode, i_SrcReg_B_Decode,
      input  i_SrcReg_A_Execute, i_SrcReg_B_Execute,
      input  i_DestReg_Execute, i_DestReg_Memory, i_DestReg_WriteBack,
      input  i_Reg_Write_Execute, i_Reg_Write_Memory, i_Reg_Write_WriteBack,
      input  i_Mem_To_Reg_Execute,
      input  i_PC_Write_Decode, i_PC_Write_Execute, i_PC_Write_Memory,
      input  i_PC_Src_WriteBack, i_Branch_Taken_Execute,
      input  i_Mem_Req_Memory, i_Mem_Ready, i_Cnt_Clear,
      output o_Forward_A_Execute, o_Forward_B_Execute,
      output o_Stall_Fetch, o_Stall_Decode, o_Stall_Execute, o_Stall_Memory,
      output o_Flush_Decode, o_Flush_Execute, o_Flush_WriteBack,
      output o_Mem_Wait, o_Stall_Count, o_Flush_Count
   );
endinterface

// File: rtl/arm_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: i_CLK, i_RESET (sync, high), i_Clear, i_Inc, o_Count.
module arm_sat_counter #(
   parameter int Width = 32
) (
   input  logic             i_CLK,
   input  logic             i_RESET,
   input  logic             i_Clear,
   input  logic             i_Inc,
   output logic [Width-1:0] o_Count
);
   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   // clear beats increment; increment stops at all-ones
   always_comb begin
      count_d = count_q;
      if (i_Clear)
         count_d = '0;
      else if (i_Inc && (count_q != {Width{1'b1}}))
         count_d = count_q + Width'(1);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign o_Count = count_q;
endmodule

// File: rtl/arm_hazard_unit.sv
// Pipeline hazard control: forwarding, load-use/PC stalls, flushes,
// memory-wait freeze FSM and stall/flush counters. Ports: i_CLK, i_RESET, hz.
module arm_hazard_unit
   import arm_hazard_pkg::*;
#(
   parameter int RegAddrWidth = 4,
   parameter int PCReg        = 15,
   parameter int CntWidth     = 32
) (
   input  logic          i_CLK,
   input  logic          i_RESET,
   arm_hazard_unit_if.slave hz
);
   localparam logic [RegAddrWidth-1:0] PcIdx = RegAddrWidth'(PCReg);

   hazard_state_t state_q;
   hazard_state_t state_d;
   logic          ld_stall;
   logic          pc_pend;
   logic          freeze;
   logic          stall_cnt_inc;
   logic          flush_cnt_inc;
   forward_sel_t  fwd_a;
   forward_sel_t  fwd_b;

   // Memory result wins over WriteBack; PC reads are never forwarded.
   function automatic forward_sel_t fwd_sel(
      input logic [RegAddrWidth-1:0] src
   );
      if (src == PcIdx)
         return FWD_REGFILE;
      if (hz.i_Reg_Write_Memory && (src == hz.i_DestReg_Memory))
         return FWD_MEMORY;
      if (hz.i_Reg_Write_WriteBack && (src == hz.i_DestReg_WriteBack))
         return FWD_WRITEBACK;
      return FWD_REGFILE;
   endfunction

   assign fwd_a = fwd_sel(hz.i_SrcReg_A_Execute);
   assign fwd_b = fwd_sel(hz.i_SrcReg_B_Execute);

   assign ld_stall = ((hz.i_SrcReg_A_Decode == hz.i_DestReg_Execute) ||
                      (hz.i_SrcReg_B_Decode == hz.i_DestReg_Execute)) &&
                     hz.i_Mem_To_Reg_Execute && hz.i_Reg_Write_Execute;
   assign pc_pend  = hz.i_PC_Write_Decode || hz.i_PC_Write_Execute ||
                     hz.i_PC_Write_Memory;
   assign freeze   = hz.i_Mem_Req_Memory && !hz.i_Mem_Ready;

   always_comb begin
      hz.o_Forward_A_Execute = FWD_REGFILE;
      hz.o_Forward_B_Execute = FWD_REGFILE;
      hz.o_Stall_Fetch       = 1'b0;
      hz.o_Stall_Decode      = 1'b0;
      hz.o_Stall_Execute     = 1'b0;
      hz.o_Stall_Memory      = 1'b0;
      hz.o_Flush_Decode      = 1'b0;
      hz.o_Flush_Execute     = 1'b0;
      hz.o_Flush_WriteBack   = 1'b0;
      if (i_RESET) begin
         hz.o_Flush_Decode    = 1'b1;
         hz.o_Flush_Execute   = 1'b1;
         hz.o_Flush_WriteBack = 1'b1;
      end else if (freeze) begin
         // hold everything; bubble WB so the held instr retires once
         hz.o_Forward_A_Execute = fwd_a;
         hz.o_Forward_B_Execute = fwd_b;
         hz.o_Stall_Fetch       = 1'b1;
         hz.o_Stall_Decode      = 1'b1;
         hz.o_Stall_Execute     = 1'b1;
         hz.o_Stall_Memory      = 1'b1;
         hz.o_Flush_WriteBack   = 1'b1;
      end else begin
         hz.o_Forward_A_Execute = fwd_a;
         hz.o_Forward_B_Execute = fwd_b;
         hz.o_Stall_Fetch       = ld_stall || pc_pend;
         hz.o_Stall_Decode      = ld_stall;
         hz.o_Flush_Decode      = pc_pend || hz.i_PC_Src_WriteBack ||
                                  hz.i_Branch_Taken_Execute;
         hz.o_Flush_Execute     = ld_stall || hz.i_Branch_Taken_Execute;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (freeze) state_d = MEM_WAIT;
         MEM_WAIT: if (hz.i_Mem_Ready || !hz.i_Mem_Req_Memory) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   assign hz.o_Mem_Wait = (state_q == MEM_WAIT);

   assign stall_cnt_inc = hz.o_Stall_Fetch;
   assign flush_cnt_inc = hz.i_Branch_Taken_Execute && !freeze;

   arm_sat_counter #(.Width(CntWidth)) u_stall_cnt (
      .i_CLK   (i_CLK),
      .i_RESET (i_RESET),
      .i_Clear (hz.i_Cnt_Clear),
      .i_Inc   (stall_cnt_inc),
      .o_Count (hz.o_Stall_Count)
   );

   arm_sat_counter #(.Width(CntWidth)) u_flush_cnt (
      .i_CLK   (i_CLK),
      .i_RESET (i_RESET),
      .i_Clear (hz.i_Cnt_Clear),
      .i_Inc   (flush_cnt_inc),
      .o_Count (hz.o_Flush_Count)
   );
endmodule

// File: tb/tb_arm_hazard_unit.sv
// Directed bench for arm_hazard_unit with 3-bit counters so that
// saturation is reachable in a few cycles.
module tb_arm_hazard_unit;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   arm_hazard_unit_if #(.RegAddrWidth(4), .CntWidth(3)) bus ();

   arm_hazard_unit #(
      .RegAddrWidth (4),
      .PCReg        (15),
      .CntWidth     (3)
   ) dut (
      .i_CLK   (clk),
      .i_RESET (rst),
      .hz      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.i_SrcReg_A_Decode      = 4'd0;
      bus.i_SrcReg_B_Decode      = 4'd0;
      bus.i_SrcReg_A_Execute     = 4'd0;
      bus.i_SrcReg_B_Execute     = 4'd0;
      bus.i_DestReg_Execute      = 4'd1;
      bus.i_DestReg_Memory       = 4'd2;
      bus.i_DestReg_WriteBack    = 4'd3;
      bus.i_Reg_Write_Execute    = 1'b0;
      bus.i_Reg_Write_Memory     = 1'b0;
      bus.i_Reg_Write_WriteBack  = 1'b0;
      bus.i_Mem_To_Reg_Execute   = 1'b0;
      bus.i_PC_Write_Decode      = 1'b0;
      bus.i_PC_Write_Execute     = 1'b0;
      bus.i_PC_Write_Memory      = 1'b0;
      bus.i_PC_Src_WriteBack     = 1'b0;
      bus.i_Branch_Taken_Execute = 1'b0;
      bus.i_Mem_Req_Memory       = 1'b0;
      bus.i_Mem_Ready            = 1'b0;
      bus.i_Cnt_Clear            = 1'b0;
   endtask

   // stalls packed {F,D,E,M}; flushes packed {D,E,WB}
   function automatic logic [3:0] stalls();
      return {bus.o_Stall_Fetch, bus.o_Stall_Decode,
              bus.o_Stall_Execute, bus.o_Stall_Memory};
   endfunction

   function automatic logic [2:0] flushes();
      return {bus.o_Flush_Decode, bus.o_Flush_Execute,
              bus.o_Flush_WriteBack};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      clk        = 1'b0;
      rst        = 1'b1;
      idle();
      // reset with a load-use pattern present: reset must dominate
      bus.i_Mem_To_Reg_Execute = 1'b1;
      bus.i_Reg_Write_Execute  = 1'b1;
      bus.i_DestReg_Execute    = 4'd5;
      bus.i_SrcReg_B_Decode    = 4'd5;
      @(posedge clk);
      step();
      check("rst_stalls", 32'(stalls()), 32'h0);
      check("rst_flushes", 32'(flushes()), 32'h7);
      check("rst_fwd", 32'({bus.o_Forward_A_Execute,
                            bus.o_Forward_B_Execute}), 32'h0);
      check("rst_memwait", 32'(bus.o_Mem_Wait), 32'h0);
      check("rst_scnt", 32'(bus.o_Stall_Count), 32'h0);
      check("rst_fcnt", 32'(bus.o_Flush_Count), 32'h0);

      rst = 1'b0;
      idle();
      step();
      check("idle_stalls", 32'(stalls()), 32'h0);
      check("idle_flushes", 32'(flushes()), 32'h0);

      // forwarding priority
      bus.i_SrcReg_A_Execute    = 4'd3;
      bus.i_DestReg_Memory      = 4'd3;
      bus.i_DestReg_WriteBack   = 4'd3;
      bus.i_Reg_Write_Memory    = 1'b1;
      bus.i_Reg_Write_WriteBack = 1'b1;
      #1;
      check("fwdA_mem", 32'(bus.o_Forward_A_Execute), 32'h2);
      bus.i_Reg_Write_Memory = 1'b0;
      #1;
      check("fwdA_wb", 32'(bus.o_Forward_A_Execute), 32'h1);
      bus.i_Reg_Write_Memory  = 1'b1;
      bus.i_SrcReg_A_Execute  = 4'd15;
      bus.i_DestReg_Memory    = 4'd15;
      bus.i_DestReg_WriteBack = 4'd15;
      #1;
      check("fwdA_pc", 32'(bus.o_Forward_A_Execute), 32'h0);
      bus.i_SrcReg_B_Execute  = 4'd7;
      bus.i_DestReg_Memory    = 4'd3;
      bus.i_DestReg_WriteBack = 4'd7;
      #1;
      check("fwdB_wb", 32'(bus.o_Forward_B_Execute), 32'h1);
      bus.i_SrcReg_B_Execute = 4'd4;
      #1;
      check("fwdB_none", 32'(bus.o_Forward_B_Execute), 32'h0);
      idle();

      // load-use
      step();
      bus.i_Mem_To_Reg_Execute = 1'b1;
      bus.i_Reg_Write_Execute  = 1'b1;
      bus.i_DestReg_Execute    = 4'd5;
      bus.i_SrcReg_B_Decode    = 4'd5;
      #1;
      check("ld_stalls", 32'(stalls()), 32'hC);
      check("ld_flushes", 32'(flushes()), 32'h2);
      step();
      check("ld_scnt", 32'(bus.o_Stall_Count), 32'h1);
      bus.i_Reg_Write_Execute = 1'b0;
      #1;
      check("ld_nowrite", 32'(stalls()), 32'h0);
      idle();

      // PC write pending in Decode
      bus.i_PC_Write_Decode = 1'b1;
      #1;
      check("pc_stalls", 32'(stalls()), 32'h8);
      check("pc_flushes", 32'(flushes()), 32'h4);
      step();
      idle();
      check("pc_scnt", 32'(bus.o_Stall_Count), 32'h2);

      // taken branch
      bus.i_Branch_Taken_Execute = 1'b1;
      #1;
      check("br_flushes", 32'(flushes()), 32'h6);
      check("br_stalls", 32'(stalls()), 32'h0);
      step();
      idle();
      check("br_fcnt", 32'(bus.o_Flush_Count), 32'h1);

      // 4-cycle memory access with coincident branch
      bus.i_Mem_Req_Memory       = 1'b1;
      bus.i_Branch_Taken_Execute = 1'b1;
      #1;
      check("mw1_stalls", 32'(stalls()), 32'hF);
      check("mw1_flushes", 32'(flushes()), 32'h1);
      check("mw1_wait", 32'(bus.o_Mem_Wait), 32'h0);
      step();
      check("mw2_stalls", 32'(stalls()), 32'hF);
      check("mw2_wait", 32'(bus.o_Mem_Wait), 32'h1);
      step();
      check("mw3_flushes", 32'(flushes()), 32'h1);
      check("mw3_wait", 32'(bus.o_Mem_Wait), 32'h1);
      check("mw3_fcnt", 32'(bus.o_Flush_Count), 32'h1);
      step();
      bus.i_Mem_Ready = 1'b1;
      #1;
      check("mw4_stalls", 32'(stalls()), 32'h0);
      check("mw4_flushes", 32'(flushes()), 32'h6);
      check("mw4_wait", 32'(bus.o_Mem_Wait), 32'h1);
      check("mw4_scnt", 32'(bus.o_Stall_Count), 32'h5);
      step();
      idle();
      check("mw5_wait", 32'(bus.o_Mem_Wait), 32'h0);
      check("mw5_fcnt", 32'(bus.o_Flush_Count), 32'h2);
      check("mw5_scnt", 32'(bus.o_Stall_Count), 32'h5);

      // single-cycle access
      bus.i_Mem_Req_Memory = 1'b1;
      bus.i_Mem_Ready      = 1'b1;
      #1;
      check("sc_stalls", 32'(stalls()), 32'h0);
      step();
      check("sc_wait", 32'(bus.o_Mem_Wait), 32'h0);
      idle();

      // reset during MEM_WAIT
      bus.i_Mem_Req_Memory = 1'b1;
      step();
      check("rw_wait", 32'(bus.o_Mem_Wait), 32'h1);
      check("rw_scnt", 32'(bus.o_Stall_Count), 32'h6);
      rst = 1'b1;
      #1;
      check("rw_stalls", 32'(stalls()), 32'h0);
      check("rw_flushes", 32'(flushes()), 32'h7);
      step();
      check("rw_wait_rst", 32'(bus.o_Mem_Wait), 32'h0);
      check("rw_scnt_rst", 32'(bus.o_Stall_Count), 32'h0);
      check("rw_fcnt_rst", 32'(bus.o_Flush_Count), 32'h0);
      rst = 1'b0;
      idle();
      step();
      check("rw_run", 32'(bus.o_Mem_Wait), 32'h0);
      check("rw_run_stalls", 32'(stalls()), 32'h0);

      // saturation and clear
      bus.i_PC_Write_Execute     = 1'b1;
      bus.i_Branch_Taken_Execute = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("sat_scnt", 32'(bus.o_Stall_Count), 32'h7);
      check("sat_fcnt", 32'(bus.o_Flush_Count), 32'h7);
      bus.i_Cnt_Clear = 1'b1;
      step();
      check("clr_scnt", 32'(bus.o_Stall_Count), 32'h0);
      check("clr_fcnt", 32'(bus.o_Flush_Count), 32'h0);
      bus.i_Cnt_Clear = 1'b0;
      step();
      check("post_clr_scnt", 32'(bus.o_Stall_Count), 32'h1);
      idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule

// File: doc/arm_hazard_unit.md
# arm_hazard_unit

Parametrised hazard-control block for the five-stage pipelined ARM core (Fetch, Decode, Execute, Memory, WriteBack). It generates forwarding selects, load-use and PC-write stalls, and branch flushes. It also adds a variable-latency data-memory wait handshake that freezes the whole pipeline, plus saturating performance counters. It sits beside the datapath and controller in the CPU top and replaces ad-hoc stall/flush wiring.

## Interface
Parameters:
- RegAddrWidth, 4, register-index width (2^RegAddrWidth architectural registers)
- PCReg, 15, index of the PC register; never forwarded
- CntWidth, 32, width of each performance counter

Ports (one clock; reset is synchronous and active-high):
- i_CLK  in  1  clock, rising edge
- i_RESET  in  1  synchronous active-high reset
- i_SrcReg_A_Decode, i_SrcReg_B_Decode  in  RegAddrWidth  Decode-stage source registers
- i_SrcReg_A_Execute, i_SrcReg_B_Execute  in  RegAddrWidth  Execute-stage source registers
- i_DestReg_Execute, i_DestReg_Memory, i_DestReg_WriteBack  in  RegAddrWidth  per-stage destination registers
- i_Reg_Write_Execute, i_Reg_Write_Memory, i_Reg_Write_WriteBack  in  1  per-stage register-write enables
- i_Mem_To_Reg_Execute  in  1  Execute-stage instruction is a load
- i_PC_Write_Decode, i_PC_Write_Execute, i_PC_Write_Memory  in  1  instruction writing PC is in that stage
- i_PC_Src_WriteBack  in  1  PC write is retiring this cycle
- i_Branch_Taken_Execute  in  1  branch resolved taken in Execute
- i_Mem_Req_Memory  in  1  Memory stage is accessing data memory
- i_Mem_Ready  in  1  data memory completes the access this cycle
- i_Cnt_Clear  in  1  synchronous clear of both counters
- o_Forward_A_Execute, o_Forward_B_Execute  out  2  00 register file, 01 WriteBack result, 10 Memory ALU result
- o_Stall_Fetch, o_Stall_Decode, o_Stall_Execute, o_Stall_Memory  out  1  hold the stage register
- o_Flush_Decode, o_Flush_Execute, o_Flush_WriteBack  out  1  load a bubble into the stage register
- o_Mem_Wait  out  1  registered; FSM is in MEM_WAIT
- o_Stall_Count, o_Flush_Count  out  CntWidth  saturating performance counters

## Operation
- Forwarding, per operand X: 10 if SrcReg_X_Execute==DestReg_Memory and Reg_Write_Memory; else 01 if it matches DestReg_WriteBack and Reg_Write_WriteBack; else 00. Memory has priority over WriteBack. The select is forced to 00 when SrcReg_X_Execute==PCReg.
- Load-use (LdStall): (SrcReg_A_Decode==DestReg_Execute or SrcReg_B_Decode==DestReg_Execute) and i_Mem_To_Reg_Execute and i_Reg_Write_Execute.
- PCPend: PC_Write_Decode or PC_Write_Execute or PC_Write_Memory.
- Freeze: i_Mem_Req_Memory and not i_Mem_Ready.
- When Freeze is not asserted:
  - Stall_Fetch = LdStall or PCPend
  - Stall_Decode = LdStall
  - Stall_Execute = 0, Stall_Memory = 0
  - Flush_Decode = PCPend or PC_Src_WriteBack or Branch_Taken_Execute
  - Flush_Execute = LdStall or Branch_Taken_Execute
  - Flush_WriteBack = 0
- When Freeze is asserted, it overrides everything above:
  - all four stalls = 1
  - Flush_Decode = 0, Flush_Execute = 0
  - Flush_WriteBack = 1, so no duplicate retirement
  - the held branch or load-use is handled in the first unfrozen cycle
- FSM has two states, RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when Freeze
  - MEM_WAIT -> RUN when i_Mem_Ready or not i_Mem_Req_Memory
  - otherwise the state holds
  - o_Mem_Wait = (state == MEM_WAIT)
- Stall_Count increments by 1 on each cycle with o_Stall_Fetch high.
- Flush_Count increments by 1 on each cycle with unfrozen Branch_Taken_Execute.
- Both counters saturate at 2^CntWidth-1. i_Cnt_Clear wins over an increment.

## Timing
- Forward, stall and flush outputs are combinational from the inputs, valid in the same cycle.
- FSM state and counters update on the rising i_CLK edge and are visible one cycle later.
- While i_RESET is high:
  - stalls = 0
  - Flush_Decode = Flush_Execute = Flush_WriteBack = 1
  - forwards = 00
- On the first edge with i_RESET high, on every such edge, and after reset:
  - state = RUN, o_Mem_Wait = 0
  - counters = 0
- Reset asserted during MEM_WAIT returns the FSM to RUN on that edge, with no residual freeze.
- A single-cycle memory access (i_Mem_Ready high together with i_Mem_Req_Memory) causes no freeze and no FSM transition.
- For an N-cycle wait, Freeze is high for N-1 cycles and o_Mem_Wait is high for the same count, delayed by one cycle.

## Structure
- Package arm_hazard_pkg holds:
  - typedef enum forward_sel_t: FWD_REGFILE=2'b00, FWD_WRITEBACK=2'b01, FWD_MEMORY=2'b10
  - typedef enum hazard_state_t: RUN, MEM_WAIT
- Sub-module arm_sat_counter (params Width; ports i_CLK, i_RESET, i_Clear, i_Inc, o_Count) is instantiated twice.

## Test plan
- Forward priority: Src_A_Execute=3, Dest_Memory=3, Dest_WriteBack=3, both write enables high -> Forward_A=10. Drop Reg_Write_Memory -> 01. Src_A_Execute=15 with matches -> 00.
- Load-use: Mem_To_Reg_Execute=1, Reg_Write_Execute=1, Dest_Execute=5, Src_B_Decode=5 -> Stall_Fetch=1, Stall_Decode=1, Flush_Execute=1, Flush_Decode=0. After one cycle, Stall_Count=1.
- Branch plus PC pending: Branch_Taken_Execute=1 -> Flush_Decode=1, Flush_Execute=1, Stall_Fetch=0. Next cycle Flush_Count=1.
- Memory wait: Mem_Req high, Mem_Ready low for 3 cycles then high -> all stalls=1 and Flush_WriteBack=1 for 3 cycles. o_Mem_Wait high on cycles 2-4. Coincident Branch_Taken_Execute gives no flush until unfrozen.
- Reset mid-wait: assert i_RESET in cycle 2 of MEM_WAIT -> o_Mem_Wait=0, counters=0, flushes=1 during reset, RUN afterwards.
- Saturation: CntWidth=3, hold stall 10 cycles -> o_Stall_Count stays 7. i_Cnt_Clear together with stall -> 0.
